// File: rtl/redun_to_bin_axis.sv
// Collapses a frame of redundant (WRD_BITS+1)-bit coefficients into plain binary by word-serial
// carry propagation, then re-emits {result, seed, t_count} as an AXI stream.
module redun_to_bin_axis #(
   parameter int AXI_LEN   = 32,
   parameter int T_LEN     = 64,
   parameter int SEED_BITS = 16,
   parameter int NUM_WRDS  = 65,
   parameter int WRD_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic [AXI_LEN-1:0]   s_axis_tdata,
   input  logic [AXI_LEN/8-1:0] s_axis_tkeep,
   input  logic                 s_axis_tlast,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [AXI_LEN-1:0]   m_axis_tdata,
   output logic [AXI_LEN/8-1:0] m_axis_tkeep,
   output logic                 m_axis_tlast,
   output logic                 busy,
   output logic                 frame_err
);
   localparam int HDR_BITS  = T_LEN + SEED_BITS;
   localparam int CW        = WRD_BITS + 1;
   localparam int SW        = WRD_BITS + 2;
   localparam int IN_BITS   = HDR_BITS + NUM_WRDS * CW;
   localparam int RES_WBITS = NUM_WRDS * WRD_BITS;
   localparam int RES_BITS  = RES_WBITS + 2;
   localparam int OUT_BITS  = HDR_BITS + RES_BITS;
   localparam int IN_BEATS  = (IN_BITS + AXI_LEN - 1) / AXI_LEN;
   localparam int OUT_BEATS = (OUT_BITS + AXI_LEN - 1) / AXI_LEN;
   localparam int OUT_PAD   = OUT_BEATS * AXI_LEN;
   localparam int BW        = $clog2(IN_BEATS + 1);
   localparam int WW        = $clog2(NUM_WRDS + 1);
   localparam int TW        = $clog2(OUT_BEATS + 1);

   typedef enum logic [1:0] {RX, DRAIN, CONV, TX} state_t;
   state_t state_q, state_d;

   logic [IN_BITS-1:0]   in_buf_q;
   logic [IN_BITS-1:0]   in_wr;
   logic [RES_WBITS-1:0] res_q, res_d;
   logic [1:0]           res_top_q;
   logic [1:0]           carry_q;
   logic [BW-1:0]        beat_cnt_q;
   logic [WW-1:0]        wrd_cnt_q;
   logic [TW-1:0]        tx_cnt_q;
   logic                 frame_err_q;
   logic                 rx_ready, rx_acc, rx_last_beat, wrd_last, tx_acc, tx_last;
   logic [SW-1:0]        sum;
   logic [OUT_PAD-1:0]   out_pad;
   logic [AXI_LEN-1:0]   tx_mux [OUT_BEATS+1];
   logic                 unused_tkeep;

   assign rx_ready     = (state_q == RX) || (state_q == DRAIN);
   assign rx_acc       = s_axis_tvalid && rx_ready;
   assign rx_last_beat = (beat_cnt_q == BW'(IN_BEATS - 1));
   assign wrd_last     = (wrd_cnt_q == WW'(NUM_WRDS - 1));
   assign tx_last      = (tx_cnt_q == TW'(OUT_BEATS - 1));
   assign tx_acc       = (state_q == TX) && m_axis_tready;

   // Each beat slot is written only while RX holds that beat index; the last slot keeps only
   // the bits that fit inside the frame.
   genvar gi;
   generate
      for (gi = 0; gi < IN_BEATS; gi++) begin : g_in_slot
         localparam int LO = gi * AXI_LEN;
         localparam int W  = (IN_BITS - LO < AXI_LEN) ? (IN_BITS - LO) : AXI_LEN;
         assign in_wr[LO +: W] = (state_q == RX && beat_cnt_q == BW'(gi)) ?
                                 s_axis_tdata[W-1:0] : in_buf_q[LO +: W];
      end
   endgenerate

   // The coefficient field shifts down one coefficient per CONV cycle, so the current one is
   // always at the bottom; result words enter at the top and end up in order after NUM_WRDS steps.
   assign sum = SW'(in_buf_q[HDR_BITS +: CW]) + SW'(carry_q);

   always_comb begin
      res_d = res_q >> WRD_BITS;
      res_d[RES_WBITS-1 -: WRD_BITS] = sum[WRD_BITS-1:0];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RX: begin
            if (rx_acc) begin
               if (s_axis_tlast)      state_d = CONV;
               else if (rx_last_beat) state_d = DRAIN;
            end
         end
         DRAIN:   if (rx_acc && s_axis_tlast) state_d = CONV;
         CONV:    if (wrd_last) state_d = TX;
         TX:      if (tx_acc && tx_last) state_d = RX;
         default: state_d = RX;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= RX;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_buf_q    <= '0;
         res_q       <= '0;
         res_top_q   <= '0;
         carry_q     <= '0;
         beat_cnt_q  <= '0;
         wrd_cnt_q   <= '0;
         tx_cnt_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         case (state_q)
            RX: begin
               if (rx_acc) begin
                  in_buf_q <= in_wr;
                  if (s_axis_tlast || rx_last_beat) beat_cnt_q <= '0;
                  else                              beat_cnt_q <= beat_cnt_q + 1'b1;
                  if (s_axis_tlast != rx_last_beat) frame_err_q <= 1'b1;
                  carry_q   <= '0;
                  wrd_cnt_q <= '0;
               end
            end
            CONV: begin
               in_buf_q[IN_BITS-1:HDR_BITS] <= in_buf_q[IN_BITS-1:HDR_BITS] >> CW;
               res_q <= res_d;
               if (wrd_last) begin
                  res_top_q <= sum[WRD_BITS+1:WRD_BITS];
                  carry_q   <= '0;
                  wrd_cnt_q <= '0;
               end else begin
                  carry_q   <= sum[WRD_BITS+1:WRD_BITS];
                  wrd_cnt_q <= wrd_cnt_q + 1'b1;
               end
            end
            TX: begin
               if (tx_acc) begin
                  if (tx_last) begin
                     tx_cnt_q <= '0;
                     in_buf_q <= '0;
                  end else begin
                     tx_cnt_q <= tx_cnt_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // The header stays in the input buffer until the frame has been sent, so it is read in place.
   always_comb begin
      out_pad = '0;
      out_pad[OUT_BITS-1:0] = {res_top_q, res_q, in_buf_q[HDR_BITS-1:0]};
   end

   assign tx_mux[0] = '0;
   generate
      for (gi = 0; gi < OUT_BEATS; gi++) begin : g_tx_beat
         assign tx_mux[gi+1] = tx_mux[gi] |
                               ((tx_cnt_q == TW'(gi)) ? out_pad[gi*AXI_LEN +: AXI_LEN] : '0);
      end
   endgenerate

   assign m_axis_tdata  = tx_mux[OUT_BEATS];
   assign m_axis_tvalid = (state_q == TX);
   assign m_axis_tlast  = m_axis_tvalid && tx_last;
   assign m_axis_tkeep  = {(AXI_LEN/8){m_axis_tvalid}};
   assign s_axis_tready = rx_ready && !rst;
   assign busy          = !(state_q == RX && beat_cnt_q == '0);
   assign frame_err     = frame_err_q;
   assign unused_tkeep  = ^s_axis_tkeep;

endmodule

// File: tb/tb_redun_to_bin_axis.sv
// Directed bench for redun_to_bin_axis in the 4-word configuration (5 input beats, 5 output beats).
module tb_redun_to_bin_axis;
   localparam int AXI_LEN   = 32;
   localparam int T_LEN     = 64;
   localparam int SEED_BITS = 16;
   localparam int NUM_WRDS  = 4;
   localparam int WRD_BITS  = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [31:0] s_axis_tdata = '0;
   logic [3:0]  s_axis_tkeep = 4'hF;
   logic        s_axis_tlast = 1'b0;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic [31:0] m_axis_tdata;
   logic [3:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        busy;
   logic        frame_err;

   int          cyc = 0;
   int          n_vec = 0;
   int          n_bad = 0;
   int          last_acc_cyc = 0;
   logic [31:0] in_beats [16];
   logic        in_last [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   redun_to_bin_axis #(
      .AXI_LEN(AXI_LEN), .T_LEN(T_LEN), .SEED_BITS(SEED_BITS),
      .NUM_WRDS(NUM_WRDS), .WRD_BITS(WRD_BITS)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .busy(busy), .frame_err(frame_err)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   // Input frame: t_count, seed, then coef0..coef3 of 17 bits each, split into 32-bit beats.
   task automatic make_frame(input int off, input logic [63:0] t, input logic [15:0] seed,
                             input logic [67:0] coefs);
      logic [159:0] fr;
      fr = '0;
      fr[63:0]   = t;
      fr[79:64]  = seed;
      fr[147:80] = coefs;
      for (int k = 0; k < 5; k++) begin
         in_beats[off+k] = fr[32*k +: 32];
         in_last[off+k]  = (k == 4);
      end
   endtask

   function automatic logic [159:0] model(input logic [63:0] t, input logic [15:0] seed,
                                          input logic [67:0] coefs);
      logic [65:0] res;
      res = '0;
      for (int i = 0; i < 4; i++) res = res + (66'(coefs[17*i +: 17]) << (16*i));
      return {14'b0, res, seed, t};
   endfunction

   task automatic send(input int first, input int n, output bit timeout);
      int g;
      timeout = 0;
      for (int b = first; b < first + n; b++) begin
         g = 0;
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = in_beats[b];
         s_axis_tlast  = in_last[b];
         while (!s_axis_tready && g < 200) begin
            @(posedge clk); #1; g++;
         end
         if (!s_axis_tready) begin
            timeout = 1;
            break;
         end
         @(posedge clk); #1;
         last_acc_cyc = cyc;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic recv(input bit toggle, input int nb, output logic [159:0] flat,
                       output logic [4:0] lasts, output bit keep_bad, output bit unstable,
                       output bit overlap, output bit timeout, output int first_cyc);
      int got, g;
      bit stalled;
      logic [31:0] held_d;
      logic held_l;
      flat = '0; lasts = '0; keep_bad = 0; unstable = 0; overlap = 0; timeout = 0;
      first_cyc = -1; got = 0; g = 0; stalled = 0; held_d = '0; held_l = 1'b0;
      while (got < nb) begin
         if (g >= 100) begin
            timeout = 1;
            break;
         end
         m_axis_tready = toggle ? (g % 2 == 0) : 1'b1;
         if (m_axis_tvalid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (s_axis_tready) overlap = 1;
            if (stalled && (m_axis_tdata !== held_d || m_axis_tlast !== held_l)) unstable = 1;
            if (m_axis_tkeep !== 4'hF) keep_bad = 1;
            if (m_axis_tready) begin
               flat[32*got +: 32] = m_axis_tdata;
               lasts[got] = m_axis_tlast;
               got++;
               stalled = 0;
            end else begin
               stalled = 1;
               held_d = m_axis_tdata;
               held_l = m_axis_tlast;
            end
         end
         @(posedge clk); #1; g++;
      end
      m_axis_tready = 1'b0;
      $display("frame out: %0d beats tdata=%h tlast=%b", got, flat, lasts);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL reset_tready_in_rst: got %b, expected 0", s_axis_tready); end
      rst = 1'b0;
      #1;
      n_vec++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL reset_tready_after: got %b, expected 1", s_axis_tready); end
      n_vec++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b, expected 0", m_axis_tvalid); end
      n_vec++; if (m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %b, expected 0", m_axis_tlast); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
   endtask

   task automatic test_basic();
      logic [159:0] flat, exp;
      logic [4:0] lasts;
      bit kb, un, ov, to, sto;
      int fc;
      make_frame(0, 64'd1000, 16'hBEEF, {17'h0, 17'h0, 17'h1FFFF, 17'h1FFFF});
      exp = {14'b0, 66'h2_0000_FFFF, 16'hBEEF, 64'd1000};
      send(0, 5, sto);
      n_vec++; if (sto !== 1'b0) begin n_bad++; $display("FAIL basic_send_timeout: got %b, expected 0", sto); end
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_conv: got %b, expected 1", busy); end
      recv(0, 5, flat, lasts, kb, un, ov, to, fc);
      n_vec++; if (flat !== exp) begin n_bad++; $display("FAIL basic_data: got %h, expected %h", flat, exp); end
      n_vec++; if (lasts !== 5'b10000) begin n_bad++; $display("FAIL basic_tlast: got %b, expected 10000", lasts); end
      n_vec++; if (kb !== 1'b0) begin n_bad++; $display("FAIL basic_tkeep: got bad=%b, expected all-ones keep", kb); end
      n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL basic_frame_err: got %b, expected 0", frame_err); end
      n_vec++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got tvalid=%b busy=%b, expected 0 0", m_axis_tvalid, busy); end
   endtask

   task automatic test_all_ones();
      logic [159:0] flat, exp;
      logic [4:0] lasts;
      bit kb, un, ov, to, sto;
      int fc;
      make_frame(0, 64'hFEDC_BA98_7654_3210, 16'h0001, {4{17'h1FFFF}});
      exp = {14'b0, 66'h2_0001_0001_0000_FFFF, 16'h0001, 64'hFEDC_BA98_7654_3210};
      send(0, 5, sto);
      recv(0, 5, flat, lasts, kb, un, ov, to, fc);
      n_vec++; if (flat !== exp) begin n_bad++; $display("FAIL allones_data: got %h, expected %h", flat, exp); end
      n_vec++; if (lasts !== 5'b10000 || to !== 1'b0) begin n_bad++; $display("FAIL allones_tlast: got %b timeout=%b, expected 10000 0", lasts, to); end
   endtask

   task automatic test_stall();
      logic [159:0] flat, exp;
      logic [67:0] coefs;
      logic [63:0] t;
      logic [15:0] seed;
      logic [4:0] lasts;
      bit kb, un, ov, to, sto;
      int fc;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) coefs[17*i +: 17] = 17'($urandom_range(0, 32'h1FFFF));
         t = {$urandom, $urandom};
         seed = 16'($urandom);
         make_frame(0, t, seed, coefs);
         exp = model(t, seed, coefs);
         send(0, 5, sto);
         recv(1, 5, flat, lasts, kb, un, ov, to, fc);
         n_vec++; if (flat !== exp) begin n_bad++; $display("FAIL stall_data[%0d]: got %h, expected %h", r, flat, exp); end
         n_vec++; if (un !== 1'b0) begin n_bad++; $display("FAIL stall_stable[%0d]: got unstable=%b, expected 0", r, un); end
         n_vec++; if (lasts !== 5'b10000) begin n_bad++; $display("FAIL stall_tlast[%0d]: got %b, expected 10000", r, lasts); end
         // Edges from the last accept edge to the first edge after which tvalid is seen high.
         n_vec++; if (fc - last_acc_cyc !== NUM_WRDS) begin n_bad++; $display("FAIL stall_latency[%0d]: got %0d edges, expected %0d", r, fc - last_acc_cyc, NUM_WRDS); end
      end
   endtask

   task automatic test_frame_err();
      logic [159:0] flat, exp;
      logic [4:0] lasts;
      bit kb, un, ov, to, sto;
      int fc;
      make_frame(0, 64'h1122_3344_5566_7788, 16'h5A5A, {17'h00007, 17'h00009, 17'h00005, 17'h1ABCD});
      in_last[2] = 1'b1;
      exp = {14'b0, 66'h0ABCD, 16'h5A5A, 64'h1122_3344_5566_7788};
      send(0, 3, sto);
      n_vec++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL short_frame_err: got %b, expected 1", frame_err); end
      recv(0, 5, flat, lasts, kb, un, ov, to, fc);
      n_vec++; if (flat !== exp) begin n_bad++; $display("FAIL short_data: got %h, expected %h", flat, exp); end
      n_vec++; if (lasts !== 5'b10000) begin n_bad++; $display("FAIL short_tlast: got %b, expected 10000", lasts); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b, expected 0", frame_err); end
      make_frame(0, 64'hA5A5_0000_1234_5678, 16'h0F0F, {17'h00003, 17'h1FFFF, 17'h10000, 17'h0FFFF});
      in_last[4]  = 1'b0;
      in_beats[5] = 32'hDEAD_BEEF; in_last[5] = 1'b0;
      in_beats[6] = 32'h1234_5678; in_last[6] = 1'b1;
      exp = {14'b0, 66'h5_0000_0000_FFFF, 16'h0F0F, 64'hA5A5_0000_1234_5678};
      send(0, 7, sto);
      n_vec++; if (sto !== 1'b0 || frame_err !== 1'b1) begin n_bad++; $display("FAIL long_frame_err: got err=%b timeout=%b, expected 1 0", frame_err, sto); end
      recv(0, 5, flat, lasts, kb, un, ov, to, fc);
      n_vec++; if (flat !== exp) begin n_bad++; $display("FAIL long_data: got %h, expected %h", flat, exp); end
   endtask

   task automatic test_rst_mid();
      logic [159:0] flat, exp;
      logic [4:0] lasts;
      bit kb, un, ov, to, sto;
      int fc;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      make_frame(0, 64'h0123_4567_89AB_CDEF, 16'h7777, {17'h1_0000, 17'h0_0001, 17'h1_8000, 17'h0_4000});
      send(0, 5, sto);
      recv(0, 2, flat, lasts, kb, un, ov, to, fc);
      n_vec++; if (m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL mid_beat2_valid: got %b, expected 1", m_axis_tvalid); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_outputs: got tvalid=%b tready=%b, expected 0 0", m_axis_tvalid, s_axis_tready); end
      rst = 1'b0;
      #1;
      n_vec++; if (s_axis_tready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_idle: got tready=%b busy=%b, expected 1 0", s_axis_tready, busy); end
      make_frame(0, 64'h0000_0000_CAFE_F00D, 16'h1357, {17'h12345, 17'h0ABCD, 17'h1FFFE, 17'h00001});
      exp = model(64'h0000_0000_CAFE_F00D, 16'h1357, {17'h12345, 17'h0ABCD, 17'h1FFFE, 17'h00001});
      send(0, 5, sto);
      recv(0, 5, flat, lasts, kb, un, ov, to, fc);
      n_vec++; if (flat !== exp) begin n_bad++; $display("FAIL mid_new_frame: got %h, expected %h", flat, exp); end
   endtask

   task automatic test_back_to_back();
      logic [159:0] fa, fb, ea, eb;
      logic [4:0] la, lb;
      bit kba, una, ova, toa, kbb, unb, ovb, tob, sto;
      int fca, fcb;
      make_frame(0, 64'd42, 16'hAAAA, {17'h1FFFF, 17'h00000, 17'h1FFFF, 17'h10001});
      make_frame(5, 64'd43, 16'h5555, {17'h00001, 17'h1FFFF, 17'h0FFFF, 17'h1FFFF});
      ea = model(64'd42, 16'hAAAA, {17'h1FFFF, 17'h00000, 17'h1FFFF, 17'h10001});
      eb = model(64'd43, 16'h5555, {17'h00001, 17'h1FFFF, 17'h0FFFF, 17'h1FFFF});
      fork
         send(0, 10, sto);
         begin
            recv(0, 5, fa, la, kba, una, ova, toa, fca);
            recv(0, 5, fb, lb, kbb, unb, ovb, tob, fcb);
         end
      join
      n_vec++; if (sto !== 1'b0) begin n_bad++; $display("FAIL b2b_send_timeout: got %b, expected 0", sto); end
      n_vec++; if (fa !== ea) begin n_bad++; $display("FAIL b2b_frame0: got %h, expected %h", fa, ea); end
      n_vec++; if (fb !== eb) begin n_bad++; $display("FAIL b2b_frame1: got %h, expected %h", fb, eb); end
      n_vec++; if ((ova | ovb) !== 1'b0) begin n_bad++; $display("FAIL b2b_tready_in_tx: got %b, expected 0", ova | ovb); end
      n_vec++; if (la !== 5'b10000 || lb !== 5'b10000) begin n_bad++; $display("FAIL b2b_tlast: got %b %b, expected 10000 10000", la, lb); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_all_ones();
      test_stall();
      test_frame_err();
      test_rst_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
